cplx_frame_acc: RTL and testbench
=================================

// Module: cplx_frame_acc
// PURPOSE
//  Downstream stage of the complex add/multiply datapath. Consumes the 2*WIDTH-bit complex
//  product stream (real/imag) and accumulates FRAME_LEN products into one complex sum
//  (coherent correlation / dot product). Presents the sum on a valid/ready output.
//  Input side is valid/ready; the block stalls upstream while a result is unconsumed.
// PARAMETERS
//  WIDTH      16                        operand width upstream; product width IN_W = 2*WIDTH
//  FRAME_LEN  8                         products per frame, >= 2
//  ACC_W      2*WIDTH+$clog2(FRAME_LEN) accumulator/output width per component, >= 2*WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      product sample valid
//  in_ready   out  1      block accepts sample this cycle
//  in_real    in   IN_W   signed product real part
//  in_imag    in   IN_W   signed product imag part
//  clear      in   1      synchronous frame abort: discard partial sum, restart count
//  out_valid  out  1      frame sum valid
//  out_ready  in   1      consumer accepts sum
//  out_real   out  ACC_W  signed frame sum real
//  out_imag   out  ACC_W  signed frame sum imag
//  ovf        out  1      sticky overflow flag (CPLX_ACC_SAT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ACCUM, acc=0, count=0, out_valid=0, out_real/imag=0, ovf=0.
//  - FSM ACCUM: in_ready=1. Accept when in_valid&&in_ready: acc += sign-extended in; count++.
//    Accept at count==FRAME_LEN-1: out_* <= acc+in, out_valid<=1, acc<=0, count<=0, -> HOLD.
//  - Latency: out_valid asserts the cycle after the FRAME_LEN-th accept.
//  - FSM HOLD: in_ready=0; out_* stable while out_valid && !out_ready.
//    out_valid&&out_ready -> out_valid<=0, -> ACCUM. No same-cycle new accept (1 bubble).
//  - clear in ACCUM: acc<=0, count<=0; clear wins over a simultaneous accept (sample dropped).
//    clear in HOLD: ignored; pending result still delivered.
//  - Arithmetic: two's complement, inputs sign-extended to ACC_W+1, add computed at ACC_W+1.
//  - out_real/out_imag registered; in_ready/out_valid are pure functions of state (no comb path
//    from out_ready to in_ready).
//  - Reset asserted mid-frame or in HOLD: partial sum and pending result discarded.
// CONFIGURATION
//  CPLX_ACC_SAT_EN defined: each add saturates per component to
//   [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any saturation sets ovf, cleared only by reset.
//  CPLX_ACC_SAT_EN undefined: two's-complement wrap at ACC_W bits; ovf tied 0.
//   Default ACC_W makes overflow impossible; macro matters only for reduced ACC_W.
// STRUCTURE
//  - cplx_pkg: typedef enum logic {ACCUM, HOLD} acc_state_e; localparam IN_W function;
//    function sat_add(a,b,w) shared with future MAC stages.
//  - One sub-module: cplx_sat_adder (one component add, sat/wrap per macro), instanced twice.
//  - Top holds FSM, frame counter ($clog2(FRAME_LEN) bits), output registers.
// TESTING (WIDTH=16, FRAME_LEN=4, default ACC_W=34 unless noted)
//  1 Reset: rst_n=0 -> out_valid=0, out_real=out_imag=0, ovf=0; after release in_ready=1.
//  2 Frame: (1+2i),(3-4i),(-5+6i),(7+0i), back-to-back, out_ready=1
//    -> out=(6+4i), out_valid one cycle after 4th accept, for exactly 1 cycle.
//  3 Backpressure: complete frame with out_ready=0 for 5 cycles -> out_* stable, in_ready=0,
//    in_valid ignored; out_ready=1 -> handshake, in_ready=1 next cycle.
//  4 Clear: 2 samples (9+9i), clear=1 with in_valid=1, then 4x(1+1i) -> out=(4+4i).
//  5 Sat (CPLX_ACC_SAT_EN, ACC_W=33): 4x real=2^31-1 -> out_real=2^32-1, ovf=1 sticky;
//    without macro same stimulus -> out_real = wrapped (4*(2^31-1)) mod 2^33 signed = -4, ovf=0.
//  6 Reset mid-frame: 3 samples (5+5i), pulse rst_n, 4x(2-1i) -> out=(8-4i).

Source files
------------

// File: rtl/cplx_pkg.sv
// Shared types and helpers for the complex datapath: FSM state encoding, product width,
// and a saturating add reused by the accumulator and future MAC stages.
package cplx_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} acc_state_e;

  // Widest component sum sat_add can handle; callers sign-extend into this width.
  localparam int SAT_W = 64;

  function automatic int in_w(input int width);
    return 2 * width;
  endfunction

  // Returns {sat_flag, result}; result is clamped to the signed range of w bits.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int unsigned w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi  = (SAT_W+1)'(1) << (w - 1);
    hi  = hi - (SAT_W+1)'(1);
    lo  = ~hi;
    if (sum > hi) begin
      return {1'b1, hi[SAT_W-1:0]};
    end else if (sum < lo) begin
      return {1'b1, lo[SAT_W-1:0]};
    end else begin
      return {1'b0, sum[SAT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/cplx_sat_adder.sv
// One signed component add: accumulator + sign-extended product. Saturates and flags
// overflow when CPLX_ACC_SAT_EN is defined, otherwise wraps at ACC_W bits.
module cplx_sat_adder
  import cplx_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int ACC_W = 35
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  smp,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

`ifdef CPLX_ACC_SAT_EN
  logic [SAT_W:0] res;

  assign res = sat_add(SAT_W'($signed(acc)), SAT_W'($signed(smp)), ACC_W);
  assign sum = res[ACC_W-1:0];
  // Bits above ACC_W are pure sign copies after clamping; folding them in keeps every bit used.
  assign ovf = res[SAT_W] | (|(res[SAT_W-1:ACC_W] ^ {(SAT_W-ACC_W){res[ACC_W-1]}}));
`else
  // Wrap mode only keeps the low ACC_W bits of the wide sum, so add at ACC_W directly.
  assign sum = acc + ACC_W'($signed(smp));
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/cplx_frame_acc.sv
// Frame accumulator: sums FRAME_LEN complex products and holds the result on a valid/ready
// output. Optional saturation and sticky ovf flag under CPLX_ACC_SAT_EN.
module cplx_frame_acc
  import cplx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 2 * WIDTH + $clog2(FRAME_LEN),
  localparam int IN_W     = in_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_real,
  input  logic [IN_W-1:0]  in_imag,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_real,
  output logic [ACC_W-1:0] out_imag,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready. in_ready and
  // out_valid depend only on state, so out_ready never reaches in_ready combinationally.
  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [ACC_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_re, sum_im;
  logic             ovf_re, ovf_im;

  cplx_sat_adder #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_re (
    .acc(acc_re_q), .smp(in_real), .sum(sum_re), .ovf(ovf_re)
  );

  cplx_sat_adder #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add_im (
    .acc(acc_im_q), .smp(in_imag), .sum(sum_im), .ovf(ovf_im)
  );

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      ACCUM: begin
        // clear takes priority, so a sample offered alongside it is dropped.
        if (clear) begin
          acc_re_d = '0;
          acc_im_d = '0;
          count_d  = '0;
        end else if (in_valid) begin
          ovf_d = ovf_q | ovf_re | ovf_im;
          if (count_q == LAST) begin
            out_re_d = sum_re;
            out_im_d = sum_im;
            acc_re_d = '0;
            acc_im_d = '0;
            count_d  = '0;
            state_d  = HOLD;
          end else begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            count_d  = count_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cplx_frame_acc.sv
// Directed bench for cplx_frame_acc (FRAME_LEN=4): a default-width instance plus a
// 33-bit-accumulator instance for the overflow case; expectations follow CPLX_ACC_SAT_EN.
module tb_cplx_frame_acc;

  localparam int WIDTH = 16;
  localparam int FRAME_LEN = 4;
  localparam int IN_W = 32;
  localparam int ACC_W = 34;
  localparam int ACC_N = 33;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_valid_n = 1'b0;
  logic [IN_W-1:0] in_real = '0;
  logic [IN_W-1:0] in_imag = '0;
  logic clear = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready, out_valid, ovf, dbg_state;
  logic [ACC_W-1:0] out_real, out_imag;
  logic in_ready_n, out_valid_n, ovf_n, dbg_state_n;
  logic [ACC_N-1:0] out_real_n, out_imag_n;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_re_q[$];
  logic [W-1:0] exp_im_q[$];

  always #5 clk = ~clk;

  cplx_frame_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .ovf(ovf), .dbg_state(dbg_state)
  );

  cplx_frame_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_N)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_real(in_real), .in_imag(in_imag), .clear(clear),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_real(out_real_n), .out_imag(out_imag_n), .ovf(ovf_n), .dbg_state(dbg_state_n)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im, input bit narrow);
    logic rdy;
    rdy = 1'b0;
    in_real = re;
    in_imag = im;
    if (narrow) in_valid_n = 1'b1;
    else in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rdy = narrow ? in_ready_n : in_ready;
      if (rdy) break;
    end
    check("send_ready", W'(rdy), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_valid_n = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it with the head of the scoreboard.
  task automatic wait_out(input string tag, input bit narrow);
    logic v;
    logic [W-1:0] re, im;
    v = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      v = narrow ? out_valid_n : out_valid;
      if (v) break;
    end
    check({tag, "_valid"}, W'(v), W'(1));
    re = narrow ? W'($signed(out_real_n)) : W'($signed(out_real));
    im = narrow ? W'($signed(out_imag_n)) : W'($signed(out_imag));
    check({tag, "_re"}, re, exp_re_q.pop_front());
    check({tag, "_im"}, im, exp_im_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_sat_re;
    logic exp_sat_ovf;
`ifdef CPLX_ACC_SAT_EN
    exp_sat_re  = 64'd4294967295;
    exp_sat_ovf = 1'b1;
`else
    exp_sat_re  = -64'sd4;
    exp_sat_ovf = 1'b0;
`endif

    // Reset
    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_real", W'(out_real), W'(0));
    check("rst_out_imag", W'(out_imag), W'(0));
    check("rst_ovf", W'(ovf), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Back-to-back frame, exact latency and single-cycle valid
    send(32'sd1, 32'sd2, 1'b0);
    send(32'sd3, -32'sd4, 1'b0);
    send(-32'sd5, 32'sd6, 1'b0);
    check("frm_valid_early", W'(out_valid), W'(0));
    send(32'sd7, 32'sd0, 1'b0);
    check("frm_valid_lat", W'(out_valid), W'(1));
    check("frm_re", W'($signed(out_real)), W'(6));
    check("frm_im", W'($signed(out_imag)), W'(4));
    check("frm_in_ready_hold", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    check("frm_valid_drop", W'(out_valid), W'(0));
    check("frm_in_ready_back", W'(in_ready), W'(1));

    // Backpressure: result held, input ignored
    out_ready = 1'b0;
    send(32'sd10, -32'sd3, 1'b0);
    send(32'sd20, 32'sd7, 1'b0);
    send(-32'sd1, -32'sd1, 1'b0);
    send(32'sd4, 32'sd0, 1'b0);
    in_valid = 1'b1;
    in_real = 32'sd100;
    in_imag = 32'sd100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_re", W'($signed(out_real)), W'(33));
      check("bp_im", W'($signed(out_imag)), W'(3));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_in_ready", W'(in_ready), W'(1));

    // Clear drops partial sum and the simultaneous sample
    send(32'sd9, 32'sd9, 1'b0);
    send(32'sd9, 32'sd9, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(32'sd1, 32'sd1, 1'b0);
    exp_re_q.push_back(W'(4));
    exp_im_q.push_back(W'(4));
    wait_out("clr", 1'b0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) send(32'sd5, 32'sd5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", W'(out_valid), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(32'sd2, -32'sd1, 1'b0);
    exp_re_q.push_back(W'(8));
    exp_im_q.push_back(-W'(4));
    wait_out("mid_rst", 1'b0);

    // Overflow on the 33-bit accumulator
    for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'sd0, 1'b1);
    exp_re_q.push_back(exp_sat_re);
    exp_im_q.push_back(W'(0));
    wait_out("sat", 1'b1);
    check("sat_ovf_sticky", W'(ovf_n), W'(exp_sat_ovf));
    check("wide_ovf", W'(ovf), W'(0));
    check("sat_in_ready", W'(in_ready_n), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
